// File: rtl/gpio8_irq_ctrl.sv
// GPIO interrupt controller: per-pin event selection, sticky pending status with
// write-1-to-clear, and a vectored request/ack arbiter (round-robin or fixed priority).
module gpio8_irq_ctrl #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pin_hi,
   input  logic [7:0]  pin_lo,
   input  logic [7:0]  pin_pe,
   input  logic [7:0]  pin_ne,
   input  logic [7:0]  ie,
   input  logic [15:0] mode,
   input  logic [7:0]  icr,
   output logic [7:0]  ris,
   output logic [7:0]  mis,
   output logic        irq,
   output logic        irq_valid,
   output logic [2:0]  irq_id,
   input  logic        irq_ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [2:0]  id_next;
   logic [2:0]  last, last_next;
   logic [2:0]  winner;
   logic [2:0]  idx;
   logic        found;
   logic [7:0]  evt;
   logic [7:0]  clr;
   logic        hs;

   assign mis       = ris & ie;
   assign irq       = |mis;
   assign irq_valid = (state == PRESENT);
   assign hs        = irq_valid & irq_ack;

   always_comb begin
      evt = '0;
      for (int i = 0; i < 8; i++) begin
         case (mode[2*i +: 2])
            2'b00:   evt[i] = pin_hi[i];
            2'b01:   evt[i] = pin_lo[i];
            2'b10:   evt[i] = pin_pe[i];
            default: evt[i] = pin_ne[i];
         endcase
      end
   end

   assign clr = icr | (hs ? (8'b1 << irq_id) : 8'b0);

   // Set is OR-ed in after the clear so a still-active event always wins.
   always_ff @(posedge clk) begin
      if (rst) ris <= '0;
      else     ris <= (ris & ~clr) | evt;
   end

   // Round-robin starts one past the last granted pin; k=7 lands back on last itself.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < 8; k++) begin
         if (RR_EN != 0) idx = last + 3'(k + 1);
         else            idx = 3'(k);
         if (!found && mis[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      id_next    = irq_id;
      last_next  = last;
      case (state)
         IDLE: begin
            if (|mis) begin
               state_next = PRESENT;
               id_next    = winner;
            end
         end
         PRESENT: begin
            if (irq_ack) begin
               state_next = GAP;
               last_next  = irq_id;
            end else if (!mis[irq_id]) begin
               state_next = IDLE;
            end
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         irq_id <= '0;
         last   <= 3'd7;
      end else begin
         state  <= state_next;
         irq_id <= id_next;
         last   <= last_next;
      end
   end

endmodule

// File: tb/tb_gpio8_irq_ctrl.sv
// Directed bench for gpio8_irq_ctrl; a round-robin and a fixed-priority instance
// share all inputs so both arbitration policies are checked in lockstep.
module tb_gpio8_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pin_hi, pin_lo, pin_pe, pin_ne, ie, icr;
   logic [15:0] mode;
   logic        irq_ack;

   logic [7:0]  ris_a, mis_a, ris_b, mis_b;
   logic        irq_a, valid_a, irq_b, valid_b;
   logic [2:0]  id_a, id_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gpio8_irq_ctrl #(.RR_EN(1)) dut_rr (
      .clk(clk), .rst(rst), .pin_hi(pin_hi), .pin_lo(pin_lo), .pin_pe(pin_pe),
      .pin_ne(pin_ne), .ie(ie), .mode(mode), .icr(icr), .ris(ris_a), .mis(mis_a),
      .irq(irq_a), .irq_valid(valid_a), .irq_id(id_a), .irq_ack(irq_ack)
   );

   gpio8_irq_ctrl #(.RR_EN(0)) dut_fp (
      .clk(clk), .rst(rst), .pin_hi(pin_hi), .pin_lo(pin_lo), .pin_pe(pin_pe),
      .pin_ne(pin_ne), .ie(ie), .mode(mode), .icr(icr), .ris(ris_b), .mis(mis_b),
      .irq(irq_b), .irq_valid(valid_b), .irq_id(id_b), .irq_ack(irq_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pin_hi = '0; pin_lo = '0; pin_pe = '0; pin_ne = '0;
      ie = '0; icr = '0; mode = '0; irq_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mode = 16'hAAAA; ie = 8'hFF; pin_pe = 8'hFF; pin_hi = 8'hFF; irq_ack = 1'b1;
      tick();
      checks++;
      if (ris_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_ris: got %h expected 00", ris_a); end
      checks++;
      if (valid_a !== 1'b0 || id_a !== 3'd0) begin errors++; $display("[TB] FAIL reset_valid_id: got %b/%0d expected 0/0", valid_a, id_a); end
      checks++;
      if (mis_a !== 8'h00 || irq_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_mis_irq: got %h/%b expected 00/0", mis_a, irq_a); end
      do_reset();
   endtask

   task automatic test_edge_pair();
      do_reset();
      mode = 16'hAAAA; ie = 8'hFF;
      pin_pe = 8'h24;
      tick();
      pin_pe = 8'h00;
      checks++;
      if (ris_a !== 8'h24) begin errors++; $display("[TB] FAIL pair_ris: got %h expected 24", ris_a); end
      tick();
      checks++;
      if (valid_a !== 1'b1 || id_a !== 3'd2) begin errors++; $display("[TB] FAIL pair_grant2: got %b/%0d expected 1/2", valid_a, id_a); end
      checks++;
      if (valid_b !== 1'b1 || id_b !== 3'd2) begin errors++; $display("[TB] FAIL pair_grant2_fp: got %b/%0d expected 1/2", valid_b, id_b); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checks++;
      if (valid_a !== 1'b0 || ris_a !== 8'h20) begin errors++; $display("[TB] FAIL pair_ack2: got %b/%h expected 0/20", valid_a, ris_a); end
      tick();
      checks++;
      if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL pair_idle: got %b expected 0", valid_a); end
      tick();
      checks++;
      if (valid_a !== 1'b1 || id_a !== 3'd5) begin errors++; $display("[TB] FAIL pair_grant5: got %b/%0d expected 1/5", valid_a, id_a); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checks++;
      if (ris_a !== 8'h00 || irq_a !== 1'b0 || valid_a !== 1'b0) begin errors++; $display("[TB] FAIL pair_done: got %h/%b/%b expected 00/0/0", ris_a, irq_a, valid_a); end
   endtask

   task automatic test_level_clear();
      do_reset();
      mode = 16'h0000;
      pin_hi = 8'h01;
      tick();
      checks++;
      if (ris_a[0] !== 1'b1) begin errors++; $display("[TB] FAIL level_set: got %b expected 1", ris_a[0]); end
      icr = 8'h01;
      tick();
      icr = 8'h00;
      checks++;
      if (ris_a[0] !== 1'b1) begin errors++; $display("[TB] FAIL level_hold: got %b expected 1", ris_a[0]); end
      pin_hi = 8'h00;
      tick();
      checks++;
      if (ris_a[0] !== 1'b1) begin errors++; $display("[TB] FAIL level_sticky: got %b expected 1", ris_a[0]); end
      icr = 8'h01;
      tick();
      icr = 8'h00;
      checks++;
      if (ris_a !== 8'h00) begin errors++; $display("[TB] FAIL level_clear: got %h expected 00", ris_a); end
   endtask

   task automatic test_rr_sweep();
      int n;
      do_reset();
      mode = 16'h0000; ie = 8'hFF; pin_hi = 8'hFF;
      tick();
      checks++;
      if (ris_a !== 8'hFF) begin errors++; $display("[TB] FAIL sweep_ris: got %h expected FF", ris_a); end
      for (int g = 0; g < 9; g++) begin
         n = 0;
         while (valid_a !== 1'b1 && n < 6) begin
            tick();
            n++;
         end
         checks++;
         if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL sweep_timeout%0d: got valid %b expected 1", g, valid_a); end
         checks++;
         if (id_a !== 3'(g % 8)) begin errors++; $display("[TB] FAIL sweep_rr%0d: got %0d expected %0d", g, id_a, g % 8); end
         checks++;
         if (valid_b !== 1'b1 || id_b !== 3'd0) begin errors++; $display("[TB] FAIL sweep_fp%0d: got %b/%0d expected 1/0", g, valid_b, id_b); end
         irq_ack = 1'b1;
         tick();
         irq_ack = 1'b0;
      end
      checks++;
      if (ris_a !== 8'hFF) begin errors++; $display("[TB] FAIL sweep_setwins: got %h expected FF", ris_a); end
   endtask

   task automatic test_masked();
      do_reset();
      mode = 16'hAAAA; ie = 8'hF7;
      pin_pe = 8'h08;
      tick();
      pin_pe = 8'h00;
      checks++;
      if (ris_a !== 8'h08 || mis_a !== 8'h00 || irq_a !== 1'b0) begin errors++; $display("[TB] FAIL masked_status: got %h/%h/%b expected 08/00/0", ris_a, mis_a, irq_a); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL masked_novalid%0d: got %b expected 0", k, valid_a); end
      end
      ie = 8'hFF;
      #1;
      checks++;
      if (irq_a !== 1'b1 || mis_a !== 8'h08) begin errors++; $display("[TB] FAIL masked_irq: got %b/%h expected 1/08", irq_a, mis_a); end
      tick();
      checks++;
      if (valid_a !== 1'b1 || id_a !== 3'd3) begin errors++; $display("[TB] FAIL masked_grant: got %b/%0d expected 1/3", valid_a, id_a); end
   endtask

   task automatic test_withdraw();
      do_reset();
      mode = 16'hAAAA; ie = 8'hFF;
      pin_pe = 8'h10;
      tick();
      pin_pe = 8'h00;
      tick();
      checks++;
      if (valid_a !== 1'b1 || id_a !== 3'd4) begin errors++; $display("[TB] FAIL withdraw_grant: got %b/%0d expected 1/4", valid_a, id_a); end
      icr = 8'h10;
      tick();
      icr = 8'h00;
      checks++;
      if (ris_a !== 8'h00) begin errors++; $display("[TB] FAIL withdraw_ris: got %h expected 00", ris_a); end
      tick();
      checks++;
      if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL withdraw_drop: got %b expected 0", valid_a); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL withdraw_quiet%0d: got %b expected 0", k, valid_a); end
      end
   endtask

   task automatic test_reset_mid_ack();
      do_reset();
      mode = 16'hAAAA; ie = 8'hFF;
      pin_pe = 8'h81;
      tick();
      pin_pe = 8'h00;
      checks++;
      if (ris_a !== 8'h81) begin errors++; $display("[TB] FAIL rstack_ris: got %h expected 81", ris_a); end
      tick();
      checks++;
      if (valid_a !== 1'b1 || id_a !== 3'd0) begin errors++; $display("[TB] FAIL rstack_grant: got %b/%0d expected 1/0", valid_a, id_a); end
      rst = 1'b1;
      irq_ack = 1'b1;
      tick();
      rst = 1'b0;
      irq_ack = 1'b0;
      checks++;
      if (ris_a !== 8'h00 || valid_a !== 1'b0 || id_a !== 3'd0) begin errors++; $display("[TB] FAIL rstack_state: got %h/%b/%0d expected 00/0/0", ris_a, valid_a, id_a); end
      pin_pe = 8'h81;
      tick();
      pin_pe = 8'h00;
      tick();
      checks++;
      if (valid_a !== 1'b1 || id_a !== 3'd0) begin errors++; $display("[TB] FAIL rstack_search: got %b/%0d expected 1/0", valid_a, id_a); end
   endtask

   initial begin
      test_reset();
      test_edge_pair();
      test_level_clear();
      test_rr_sweep();
      test_masked();
      test_withdraw();
      test_reset_mid_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
